// File: rtl/wb_sram_slave.sv
// Wishbone classic single-transfer slave in front of a 16-bit word-addressed synchronous RAM.
// Optional write protection of the low RO_WORDS words is enabled by defining WB_SRAM_ERR_EN.
module wb_sram_slave #(
   parameter int unsigned ADDR_WIDTH  = 13,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned RO_WORDS    = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wb_cyc,
   input  logic                  wb_stb,
   input  logic                  wb_we,
   input  logic [ADDR_WIDTH-1:0] wb_adr,
   input  logic [15:0]           wb_dat_i,
   output logic [15:0]           wb_dat_o,
   output logic                  wb_ack,
   output logic                  wb_err
);

`ifdef WB_SRAM_ERR_EN
   localparam bit ErrEn = 1'b1;
`else
   localparam bit ErrEn = 1'b0;
`endif

   localparam logic [3:0] WaitLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e                state_q;
   logic [3:0]            cnt_q;
   logic [ADDR_WIDTH-1:0] adr_q;
   logic [15:0]           wdat_q;
   logic                  we_q;
   logic                  ack_q;
   logic                  err_q;
   logic [15:0]           rdat_q;
   logic [15:0]           mem [0:(2**ADDR_WIDTH)-1];

   logic req;
   logic wr_blocked;
   logic mem_we;

   assign req        = wb_cyc & wb_stb;
   // Folds to 0 when protection is compiled out.
   assign wr_blocked = ErrEn && we_q && (32'(adr_q) < RO_WORDS);
   assign mem_we     = (state_q == StResp) && we_q && !wr_blocked && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdat_q  <= 16'h0000;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req) begin
                  adr_q  <= wb_adr;
                  we_q   <= wb_we;
                  wdat_q <= wb_dat_i;
                  if (WAIT_STATES == 0) begin
                     state_q <= StResp;
                  end else begin
                     cnt_q   <= WaitLoad;
                     state_q <= StWait;
                  end
               end
            end
            StWait: begin
               // Master withdrawing the request abandons the transfer silently.
               if (!req) begin
                  cnt_q   <= 4'd0;
                  state_q <= StIdle;
               end else if (cnt_q == 4'd0) begin
                  state_q <= StResp;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StResp: begin
               state_q <= StIdle;
               if (wr_blocked) begin
                  err_q <= 1'b1;
               end else begin
                  ack_q <= 1'b1;
               end
               if (!we_q) begin
                  rdat_q <= mem[adr_q];
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[adr_q] <= wdat_q;
      end
   end

   assign wb_ack   = ack_q;
   assign wb_err   = err_q;
   assign wb_dat_o = rdat_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave: three instances with 0, 3 and 5 wait states, RO_WORDS=16.
// The protection scenario follows whichever way WB_SRAM_ERR_EN is set for the build.
module tb_wb_sram_slave;

   logic        clk;
   logic        reset;
   logic        cyc   [3];
   logic        stb   [3];
   logic        we    [3];
   logic [12:0] adr   [3];
   logic [15:0] dat_i [3];
   logic [15:0] dat_o [3];
   logic        ack   [3];
   logic        err   [3];

   int checks;
   int fails;

   logic [15:0] rd;
   int          lat;
   logic        ga;
   logic        ge;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned Ws = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
      wb_sram_slave #(
         .ADDR_WIDTH (13),
         .WAIT_STATES(Ws),
         .RO_WORDS   (16)
      ) u_dut (
         .clk     (clk),
         .reset   (reset),
         .wb_cyc  (cyc[g]),
         .wb_stb  (stb[g]),
         .wb_we   (we[g]),
         .wb_adr  (adr[g]),
         .wb_dat_i(dat_i[g]),
         .wb_dat_o(dat_o[g]),
         .wb_ack  (ack[g]),
         .wb_err  (err[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge; lt = edges between the sampling edge and the response edge.
   task automatic xfer(input int idx, input logic w, input logic [12:0] a, input logic [15:0] d,
                       output logic [15:0] r, output int lt, output logic ka, output logic ke);
      cyc[idx]   = 1'b1;
      stb[idx]   = 1'b1;
      we[idx]    = w;
      adr[idx]   = a;
      dat_i[idx] = d;
      lt = -1;
      ka = 1'b0;
      ke = 1'b0;
      r  = 16'hxxxx;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ack[idx] || err[idx]) begin
            lt = i;
            ka = ack[idx];
            ke = err[idx];
            r  = dat_o[idx];
            break;
         end
      end
      cyc[idx] = 1'b0;
      stb[idx] = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (ack[i] !== 1'b0) begin
            $display("FAIL reset_ack[%0d]: got %b expected 0", i, ack[i]); fails++;
         end
         checks++;
         if (err[i] !== 1'b0) begin
            $display("FAIL reset_err[%0d]: got %b expected 0", i, err[i]); fails++;
         end
         checks++;
         if (dat_o[i] !== 16'h0000) begin
            $display("FAIL reset_dat[%0d]: got %h expected 0000", i, dat_o[i]); fails++;
         end
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ws0_write_read();
      xfer(0, 1'b1, 13'h010, 16'hBEEF, rd, lat, ga, ge);
      checks++;
      if (lat !== 1 || ga !== 1'b1 || ge !== 1'b0) begin
         $display("FAIL ws0_write: got lat=%0d ack=%b err=%b expected lat=1 ack=1 err=0",
                  lat, ga, ge); fails++;
      end
      @(negedge clk);
      checks++;
      if (ack[0] !== 1'b0) begin
         $display("FAIL ws0_write_pulse: got ack=%b expected 0", ack[0]); fails++;
      end
      xfer(0, 1'b0, 13'h010, 16'h0000, rd, lat, ga, ge);
      checks++;
      if (lat !== 1 || ga !== 1'b1) begin
         $display("FAIL ws0_read_lat: got lat=%0d ack=%b expected lat=1 ack=1", lat, ga); fails++;
      end
      checks++;
      if (rd !== 16'hBEEF) begin
         $display("FAIL ws0_read_data: got %h expected beef", rd); fails++;
      end
      @(negedge clk);
      xfer(0, 1'b1, 13'h011, 16'h1111, rd, lat, ga, ge);
      checks++;
      if (dat_o[0] !== 16'hBEEF) begin
         $display("FAIL ws0_write_keeps_dat: got %h expected beef", dat_o[0]); fails++;
      end
      @(negedge clk);
   endtask

   task automatic test_wait_states();
      xfer(1, 1'b1, 13'h030, 16'h5A5A, rd, lat, ga, ge);
      checks++;
      if (lat !== 4 || ga !== 1'b1) begin
         $display("FAIL ws3_write: got lat=%0d ack=%b expected lat=4 ack=1", lat, ga); fails++;
      end
      @(negedge clk);
      xfer(1, 1'b0, 13'h030, 16'h0000, rd, lat, ga, ge);
      checks++;
      if (lat !== 4 || ga !== 1'b1) begin
         $display("FAIL ws3_read_lat: got lat=%0d ack=%b expected lat=4 ack=1", lat, ga); fails++;
      end
      checks++;
      if (rd !== 16'h5A5A) begin
         $display("FAIL ws3_read_data: got %h expected 5a5a", rd); fails++;
      end
      @(negedge clk);
      checks++;
      if (ack[1] !== 1'b0) begin
         $display("FAIL ws3_pulse: got ack=%b expected 0", ack[1]); fails++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (dat_o[1] !== 16'h5A5A) begin
         $display("FAIL ws3_dat_hold: got %h expected 5a5a", dat_o[1]); fails++;
      end
   endtask

   task automatic test_abort();
      logic seen;
      xfer(1, 1'b1, 13'h020, 16'h0000, rd, lat, ga, ge);
      @(negedge clk);
      cyc[1]   = 1'b1;
      stb[1]   = 1'b1;
      we[1]    = 1'b1;
      adr[1]   = 13'h020;
      dat_i[1] = 16'h1234;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 1) stb[1] = 1'b0;
         if (ack[1] || err[1]) seen = 1'b1;
      end
      cyc[1] = 1'b0;
      checks++;
      if (seen !== 1'b0) begin
         $display("FAIL abort_no_ack: got response=%b expected 0", seen); fails++;
      end
      xfer(1, 1'b0, 13'h020, 16'h0000, rd, lat, ga, ge);
      checks++;
      if (rd !== 16'h0000 || lat !== 4) begin
         $display("FAIL abort_word: got data=%h lat=%0d expected data=0000 lat=4", rd, lat);
         fails++;
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int          n;
      int          at  [4];
      logic [15:0] got [4];
      logic [15:0] exp_d [4];
      exp_d[0] = 16'h1111;
      exp_d[1] = 16'h2222;
      exp_d[2] = 16'h3333;
      exp_d[3] = 16'h4444;
      for (int j = 0; j < 4; j++) begin
         xfer(0, 1'b1, 13'(j + 1), exp_d[j], rd, lat, ga, ge);
         @(negedge clk);
         at[j]  = -1;
         got[j] = 16'hxxxx;
      end
      cyc[0] = 1'b1;
      stb[0] = 1'b1;
      we[0]  = 1'b0;
      adr[0] = 13'h001;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ack[0]) begin
            at[n]  = i;
            got[n] = dat_o[0];
            n++;
            if (n == 4) break;
            adr[0] = 13'(n + 1);
         end
      end
      cyc[0] = 1'b0;
      stb[0] = 1'b0;
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (at[j] !== 1 + 2 * j) begin
            $display("FAIL b2b_ack_cycle[%0d]: got %0d expected %0d", j, at[j], 1 + 2 * j);
            fails++;
         end
         checks++;
         if (got[j] !== exp_d[j]) begin
            $display("FAIL b2b_data[%0d]: got %h expected %h", j, got[j], exp_d[j]); fails++;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      xfer(2, 1'b1, 13'h040, 16'h0F0F, rd, lat, ga, ge);
      checks++;
      if (lat !== 6 || ga !== 1'b1) begin
         $display("FAIL ws5_write: got lat=%0d ack=%b expected lat=6 ack=1", lat, ga); fails++;
      end
      @(negedge clk);
      cyc[2]   = 1'b1;
      stb[2]   = 1'b1;
      we[2]    = 1'b1;
      adr[2]   = 13'h040;
      dat_i[2] = 16'hDEAD;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (ack[2] !== 1'b0 || err[2] !== 1'b0) begin
         $display("FAIL reset_mid_resp: got ack=%b err=%b expected 0 0", ack[2], err[2]); fails++;
      end
      reset = 1'b0;
      // Request stays asserted, so an idle FSM samples this read at the next edge.
      xfer(2, 1'b0, 13'h040, 16'h0000, rd, lat, ga, ge);
      checks++;
      if (lat !== 6 || ga !== 1'b1) begin
         $display("FAIL reset_mid_idle: got lat=%0d ack=%b expected lat=6 ack=1", lat, ga);
         fails++;
      end
      checks++;
      if (rd !== 16'h0F0F) begin
         $display("FAIL reset_mid_word: got %h expected 0f0f", rd); fails++;
      end
      @(negedge clk);
   endtask

   task automatic test_protect();
`ifdef WB_SRAM_ERR_EN
      xfer(0, 1'b1, 13'h00F, 16'hAAAA, rd, lat, ga, ge);
      checks++;
      if (ge !== 1'b1 || ga !== 1'b0 || lat !== 1) begin
         $display("FAIL ro_write_err: got err=%b ack=%b lat=%0d expected err=1 ack=0 lat=1",
                  ge, ga, lat); fails++;
      end
      @(negedge clk);
      checks++;
      if (err[0] !== 1'b0) begin
         $display("FAIL ro_err_pulse: got err=%b expected 0", err[0]); fails++;
      end
      xfer(0, 1'b0, 13'h00F, 16'h0000, rd, lat, ga, ge);
      checks++;
      if (ga !== 1'b1 || ge !== 1'b0) begin
         $display("FAIL ro_read_ack: got ack=%b err=%b expected ack=1 err=0", ga, ge); fails++;
      end
      checks++;
      if (rd === 16'hAAAA) begin
         $display("FAIL ro_word_kept: got %h expected not aaaa", rd); fails++;
      end
`else
      xfer(0, 1'b1, 13'h00F, 16'hAAAA, rd, lat, ga, ge);
      checks++;
      if (ga !== 1'b1 || ge !== 1'b0 || lat !== 1) begin
         $display("FAIL lo_write_ack: got ack=%b err=%b lat=%0d expected ack=1 err=0 lat=1",
                  ga, ge, lat); fails++;
      end
      @(negedge clk);
      xfer(0, 1'b0, 13'h00F, 16'h0000, rd, lat, ga, ge);
      checks++;
      if (rd !== 16'hAAAA) begin
         $display("FAIL lo_word_written: got %h expected aaaa", rd); fails++;
      end
`endif
      @(negedge clk);
      xfer(0, 1'b1, 13'h010, 16'h5555, rd, lat, ga, ge);
      checks++;
      if (ga !== 1'b1 || ge !== 1'b0) begin
         $display("FAIL rw_write_ack: got ack=%b err=%b expected ack=1 err=0", ga, ge); fails++;
      end
      @(negedge clk);
      xfer(0, 1'b0, 13'h010, 16'h0000, rd, lat, ga, ge);
      checks++;
      if (rd !== 16'h5555) begin
         $display("FAIL rw_word_written: got %h expected 5555", rd); fails++;
      end
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      reset  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc[i]   = 1'b0;
         stb[i]   = 1'b0;
         we[i]    = 1'b0;
         adr[i]   = 13'h000;
         dat_i[i] = 16'h0000;
      end
      @(negedge clk);
      test_reset();
      test_ws0_write_read();
      test_wait_states();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      test_protect();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

endmodule
